// File: rtl/wf68k30l_movem_sequencer.sv
// MOVEM bus-transfer sequencer: walks the register mask, issues one bus cycle per
// selected register, and reports the final An value for the (An)+ / -(An) modes.
module wf68k30l_movem_sequencer #(
  parameter int unsigned ADR_W = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             START,
  input  logic [15:0]      MASK,
  input  logic             MEM2REG,
  input  logic             PREDEC,
  input  logic             POSTINC,
  input  logic             SIZE_LONG,
  input  logic [2:0]       AN_SEL,
  input  logic [ADR_W-1:0] BASE_ADR,
  input  logic             BUS_ACK,
  input  logic             BUS_ERR,
  output logic             BUSY,
  output logic             BUS_REQ,
  output logic             BUS_WRn,
  output logic [ADR_W-1:0] BUS_ADR,
  output logic [3:0]       REG_PNTR,
  output logic             REG_WE,
  output logic             REG_SEXT,
  output logic             AN_UPDATE,
  output logic [ADR_W-1:0] AN_VALUE,
  output logic             DONE,
  output logic             ERR,
  output logic [4:0]       XFER_CNT
);

  typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;

  state_t           state;
  logic [15:0]      rem_mask;
  logic             predec_q;
  logic             postinc_q;
  logic             long_q;
  logic             mem2reg_q;
  logic [2:0]       an_sel_q;
  logic             err_q;
  logic [ADR_W-1:0] an_final;

  logic             start_ok;
  logic [3:0]       first_idx;
  logic [3:0]       next_idx;
  logic [ADR_W-1:0] step_in;
  logic [ADR_W-1:0] step_q;
  logic [ADR_W-1:0] cnt_ext;
  logic [ADR_W-1:0] delta_in;

  // Index of the lowest set bit; 0 for an empty vector (never used in that case).
  function automatic logic [3:0] lsb_index(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  // START coinciding with the DONE pulse is dropped even though the state is already IDLE.
  assign start_ok  = (state == IDLE) && START && !DONE;
  assign first_idx = lsb_index(MASK);
  assign next_idx  = lsb_index(rem_mask);
  assign step_in   = SIZE_LONG ? ADR_W'(4) : ADR_W'(2);
  assign step_q    = long_q ? ADR_W'(4) : ADR_W'(2);
  assign cnt_ext   = ADR_W'(popcount16(MASK));
  assign delta_in  = SIZE_LONG ? (cnt_ext << 2) : (cnt_ext << 1);

  // Write strobe follows the acknowledge directly; a postinc load of An itself is suppressed.
  assign REG_WE = (state == XFER) && BUS_ACK && !BUS_ERR && mem2reg_q &&
                  !(postinc_q && (REG_PNTR == {1'b1, an_sel_q}));

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= IDLE;
      rem_mask  <= 16'd0;
      predec_q  <= 1'b0;
      postinc_q <= 1'b0;
      long_q    <= 1'b0;
      mem2reg_q <= 1'b0;
      an_sel_q  <= 3'd0;
      err_q     <= 1'b0;
      an_final  <= '0;
      BUSY      <= 1'b0;
      BUS_REQ   <= 1'b0;
      BUS_WRn   <= 1'b0;
      BUS_ADR   <= '0;
      REG_PNTR  <= 4'd0;
      REG_SEXT  <= 1'b0;
      AN_UPDATE <= 1'b0;
      AN_VALUE  <= '0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      XFER_CNT  <= 5'd0;
    end else begin
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      AN_UPDATE <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            predec_q  <= PREDEC;
            postinc_q <= POSTINC && !PREDEC;
            long_q    <= SIZE_LONG;
            mem2reg_q <= MEM2REG;
            an_sel_q  <= AN_SEL;
            err_q     <= 1'b0;
            an_final  <= PREDEC ? (BASE_ADR - delta_in) : (BASE_ADR + delta_in);
            BUSY      <= 1'b1;
            BUS_WRn   <= MEM2REG;
            REG_SEXT  <= MEM2REG && !SIZE_LONG;
            XFER_CNT  <= 5'd0;
            if (MASK != 16'd0) begin
              state    <= XFER;
              BUS_REQ  <= 1'b1;
              rem_mask <= MASK & (MASK - 16'd1);
              BUS_ADR  <= PREDEC ? (BASE_ADR - step_in) : BASE_ADR;
              REG_PNTR <= PREDEC ? ~first_idx : first_idx;
            end else begin
              state    <= FIN;
              rem_mask <= 16'd0;
            end
          end
        end
        XFER: begin
          if (BUS_ERR) begin
            err_q   <= 1'b1;
            BUS_REQ <= 1'b0;
            state   <= FIN;
          end else if (BUS_ACK) begin
            XFER_CNT <= XFER_CNT + 5'd1;
            if (rem_mask != 16'd0) begin
              rem_mask <= rem_mask & (rem_mask - 16'd1);
              REG_PNTR <= predec_q ? ~next_idx : next_idx;
              BUS_ADR  <= predec_q ? (BUS_ADR - step_q) : (BUS_ADR + step_q);
            end else begin
              BUS_REQ <= 1'b0;
              state   <= FIN;
            end
          end
        end
        FIN: begin
          DONE      <= 1'b1;
          ERR       <= err_q;
          AN_UPDATE <= (predec_q || postinc_q) && !err_q;
          AN_VALUE  <= an_final;
          BUSY      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wf68k30l_movem_sequencer.sv
// Directed bench for the MOVEM sequencer: table of whole-instruction vectors with a
// per-transfer address/register model, plus hand-written reset sequences.
module tb_wf68k30l_movem_sequencer;
  localparam int unsigned ADR_W = 32;

  logic             CLK = 1'b0;
  logic             RESETn;
  logic             START;
  logic [15:0]      MASK;
  logic             MEM2REG;
  logic             PREDEC;
  logic             POSTINC;
  logic             SIZE_LONG;
  logic [2:0]       AN_SEL;
  logic [ADR_W-1:0] BASE_ADR;
  logic             BUS_ACK;
  logic             BUS_ERR;
  logic             BUSY;
  logic             BUS_REQ;
  logic             BUS_WRn;
  logic [ADR_W-1:0] BUS_ADR;
  logic [3:0]       REG_PNTR;
  logic             REG_WE;
  logic             REG_SEXT;
  logic             AN_UPDATE;
  logic [ADR_W-1:0] AN_VALUE;
  logic             DONE;
  logic             ERR;
  logic [4:0]       XFER_CNT;

  int total = 0;
  int bad   = 0;

  wf68k30l_movem_sequencer #(.ADR_W(ADR_W)) dut (
    .CLK(CLK), .RESETn(RESETn), .START(START), .MASK(MASK), .MEM2REG(MEM2REG),
    .PREDEC(PREDEC), .POSTINC(POSTINC), .SIZE_LONG(SIZE_LONG), .AN_SEL(AN_SEL),
    .BASE_ADR(BASE_ADR), .BUS_ACK(BUS_ACK), .BUS_ERR(BUS_ERR), .BUSY(BUSY),
    .BUS_REQ(BUS_REQ), .BUS_WRn(BUS_WRn), .BUS_ADR(BUS_ADR), .REG_PNTR(REG_PNTR),
    .REG_WE(REG_WE), .REG_SEXT(REG_SEXT), .AN_UPDATE(AN_UPDATE), .AN_VALUE(AN_VALUE),
    .DONE(DONE), .ERR(ERR), .XFER_CNT(XFER_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] mask;
    logic        m2r;
    logic        predec;
    logic        postinc;
    logic        lng;
    logic [2:0]  an_sel;
    logic [31:0] base;
    int          delay;
    int          err_at;
    int          n_req;
    int          exp_cnt;
    logic        exp_err;
    logic        exp_upd;
    logic        chk_anv;
    logic [31:0] exp_anv;
    int          exp_we;
    logic [31:0] first_adr;
    logic [3:0]  first_reg;
    int          done_cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          k;
    int          wait_n;
    int          we_seen;
    int          cyc;
    int          seen;
    bit          done_seen;
    logic [3:0]  bitn;
    logic [3:0]  er;
    logic [31:0] s;
    logic [31:0] ea;
    logic        exp_we;
    k = 0; wait_n = 0; we_seen = 0; done_seen = 1'b0; bitn = 4'd0;
    tick();
    MASK = v.mask; MEM2REG = v.m2r; PREDEC = v.predec; POSTINC = v.postinc;
    SIZE_LONG = v.lng; AN_SEL = v.an_sel; BASE_ADR = v.base; START = 1'b1;
    tick();
    START = 1'b0;
    chk($sformatf("v%0d busy_after_start", idx), 32'(BUSY), 32'd1);
    chk($sformatf("v%0d cnt_cleared", idx), 32'(XFER_CNT), 32'd0);
    if (v.n_req > 0) begin
      chk($sformatf("v%0d first_req", idx), 32'(BUS_REQ), 32'd1);
      chk($sformatf("v%0d first_adr", idx), BUS_ADR, v.first_adr);
      chk($sformatf("v%0d first_reg", idx), 32'(REG_PNTR), 32'(v.first_reg));
    end
    s = v.lng ? 32'd4 : 32'd2;
    cyc = 1;
    while (!done_seen && cyc < 400) begin
      BUS_ACK = 1'b0; BUS_ERR = 1'b0; START = 1'b0;
      if (DONE) begin
        done_seen = 1'b1;
        chk($sformatf("v%0d err", idx), 32'(ERR), 32'(v.exp_err));
        chk($sformatf("v%0d an_update", idx), 32'(AN_UPDATE), 32'(v.exp_upd));
        chk($sformatf("v%0d xfer_cnt", idx), 32'(XFER_CNT), 32'(v.exp_cnt));
        chk($sformatf("v%0d we_count", idx), 32'(we_seen), 32'(v.exp_we));
        chk($sformatf("v%0d req_count", idx), 32'(k), 32'(v.n_req));
        if (v.chk_anv) chk($sformatf("v%0d an_value", idx), AN_VALUE, v.exp_anv);
        if (v.done_cyc > 0) chk($sformatf("v%0d done_cycle", idx), 32'(cyc), 32'(v.done_cyc));
        START = 1'b1;
        tick();
        START = 1'b0;
        chk($sformatf("v%0d done_pulse", idx), 32'(DONE), 32'd0);
        chk($sformatf("v%0d start_on_done_ignored", idx), 32'({BUSY, BUS_REQ}), 32'd0);
      end else begin
        if (BUS_REQ) begin
          chk($sformatf("v%0d req_limit", idx), 32'(k < v.n_req), 32'd1);
          seen = 0;
          for (int j = 0; j < 16; j++) begin
            if (v.mask[j]) begin
              if (seen == k) bitn = 4'(j);
              seen++;
            end
          end
          er = v.predec ? 4'(15 - int'(bitn)) : bitn;
          ea = v.predec ? (v.base - 32'(k + 1) * s) : (v.base + 32'(k) * s);
          chk($sformatf("v%0d t%0d adr", idx, k), BUS_ADR, ea);
          chk($sformatf("v%0d t%0d reg", idx, k), 32'(REG_PNTR), 32'(er));
          chk($sformatf("v%0d t%0d wrn", idx, k), 32'(BUS_WRn), 32'(v.m2r));
          if (wait_n < v.delay) begin
            wait_n++;
          end else begin
            wait_n = 0;
            BUS_ACK = 1'b1;
            if (k == v.err_at) BUS_ERR = 1'b1;
            if (k == 1 && v.err_at >= 0) START = 1'b1;
            #1;
            exp_we = v.m2r && (k != v.err_at) &&
                     !(v.postinc && !v.predec && er == {1'b1, v.an_sel});
            chk($sformatf("v%0d t%0d reg_we", idx, k), 32'(REG_WE), 32'(exp_we));
            if (REG_WE) we_seen++;
            k++;
          end
        end
        tick();
        cyc++;
      end
    end
    BUS_ACK = 1'b0; BUS_ERR = 1'b0; START = 1'b0;
    chk($sformatf("v%0d done_seen", idx), 32'(done_seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //       mask      m2r   pre   post  long  an    base           dly err nrq cnt err   upd   chkA  anv           we first_adr      reg   dcyc
    vecs[0] = '{16'h8001, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 32'h0000_1000, 0, -1, 2, 2, 1'b0, 1'b1, 1'b1, 32'h0000_1008, 2, 32'h0000_1000, 4'd0,  0};
    vecs[1] = '{16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_2000, 0, -1, 2, 2, 1'b0, 1'b1, 1'b1, 32'h0000_1FFC, 0, 32'h0000_1FFE, 4'd15, 0};
    vecs[2] = '{16'h0800, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 32'h0000_0010, 0, -1, 1, 1, 1'b0, 1'b1, 1'b1, 32'h0000_0012, 0, 32'h0000_0010, 4'd11, 0};
    vecs[3] = '{16'h00FF, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0000_3000, 3, -1, 8, 8, 1'b0, 1'b0, 1'b0, 32'h0,         8, 32'h0000_3000, 4'd0,  0};
    vecs[4] = '{16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0000_4000, 0,  2, 3, 2, 1'b1, 1'b0, 1'b0, 32'h0,         0, 32'h0000_4000, 4'd0,  0};
    vecs[5] = '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_0000, 0, -1, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0,         0, 32'h0,         4'd0,  2};
    vecs[6] = '{16'h0001, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0000_0000, 0, -1, 1, 1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 4'd15, 0};

    RESETn = 1'b0; START = 1'b0; MASK = 16'd0; MEM2REG = 1'b0; PREDEC = 1'b0;
    POSTINC = 1'b0; SIZE_LONG = 1'b0; AN_SEL = 3'd0; BASE_ADR = '0;
    BUS_ACK = 1'b0; BUS_ERR = 1'b0;
    tick();
    tick();
    chk("reset busy_req_done", 32'({BUSY, BUS_REQ, DONE, ERR, AN_UPDATE, REG_WE}), 32'd0);
    chk("reset xfer_cnt", 32'(XFER_CNT), 32'd0);
    chk("reset bus_adr", BUS_ADR, 32'd0);
    chk("reset an_value", AN_VALUE, 32'd0);
    RESETn = 1'b1;
    tick();

    // An acknowledge with no request outstanding must have no effect.
    BUS_ACK = 1'b1;
    tick();
    BUS_ACK = 1'b0;
    chk("idle ack ignored", 32'({BUSY, BUS_REQ, XFER_CNT}), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset in the middle of a waiting transfer abandons the instruction.
    tick();
    MASK = 16'h00FF; MEM2REG = 1'b1; PREDEC = 1'b0; POSTINC = 1'b1; SIZE_LONG = 1'b1;
    AN_SEL = 3'd2; BASE_ADR = 32'h0000_5000; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    chk("rst_mid req_before", 32'({BUSY, BUS_REQ, BUS_WRn}), 32'd7);
    RESETn = 1'b0;
    #1;
    chk("rst_mid flags", 32'({BUSY, BUS_REQ, BUS_WRn, REG_WE, REG_SEXT, DONE, AN_UPDATE}), 32'd0);
    chk("rst_mid bus_adr", BUS_ADR, 32'd0);
    chk("rst_mid reg_pntr", 32'(REG_PNTR), 32'd0);
    tick();
    RESETn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("rst_after c%0d", c), 32'({BUSY, BUS_REQ, DONE, AN_UPDATE}), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wf68k30l_movem_sequencer.md
Name: wf68k30l_movem_sequencer

Overview:
- Sequences the bus transfers of one MOVEM instruction.
- Scans the 16-bit register mask, issues one bus request per selected register, and generates the transfer address and register pointer.
- For memory-to-register moves, strobes the register write. At the end, reports the final address-register value for the (An)+ and -(An) modes.
- Sits between the control unit, which decodes MOVEM, and the bus interface / register file.

Parameters:
- ADR_W, 32, address and An value width.

Ports:
- CLK  in  1  system clock.
- RESETn  in  1  asynchronous active-low reset.
- START  in  1  one-cycle start pulse; sampled only in IDLE.
- MASK  in  16  register list mask (BIW_1).
- MEM2REG  in  1  1 = memory to register, 0 = register to memory.
- PREDEC  in  1  -(An) addressing mode.
- POSTINC  in  1  (An)+ addressing mode.
- SIZE_LONG  in  1  1 = long (4 bytes), 0 = word (2 bytes).
- AN_SEL  in  3  addressing register number.
- BASE_ADR  in  ADR_W  effective address (An value for the pre/post modes).
- BUS_ACK  in  1  transfer complete.
- BUS_ERR  in  1  transfer faulted.
- BUSY  out  1  sequencer active.
- BUS_REQ  out  1  transfer request.
- BUS_WRn  out  1  1 = read, equal to MEM2REG.
- BUS_ADR  out  ADR_W  transfer address.
- REG_PNTR  out  4  register: 0-7 = D0-D7, 8-15 = A0-A7.
- REG_WE  out  1  register write strobe (memory to register).
- REG_SEXT  out  1  sign-extend word to 32 bits (MEM2REG and not SIZE_LONG).
- AN_UPDATE  out  1  one-cycle strobe: write AN_VALUE to A[AN_SEL].
- AN_VALUE  out  ADR_W  final An value.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  qualifies DONE: terminated by a bus error.
- XFER_CNT  out  5  transfers completed in the current instruction.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset asserted mid-operation drops BUS_REQ immediately and abandons the instruction; no DONE and no AN_UPDATE are produced.
- States: IDLE, XFER, FIN.
- IDLE:
  - On START, latch MASK, mode, size, AN_SEL and BASE_ADR.
  - Set BUSY the next cycle and clear XFER_CNT.
  - Latched mask nonzero: go to XFER. Mask zero: go to FIN, with no bus cycles.
- Scan order and register mapping:
  - Non-predec: mask bit i maps to register i, scanned from bit 0 upward.
  - Predec: mask bit i maps to register 15-i, scanned from bit 0 upward, so A7 is transferred first.
  - The next set bit is found by a combinational priority encoder over the remaining mask, so selection costs no extra cycles. A served bit is cleared from the remaining mask.
- Addresses (step S = 4 if SIZE_LONG, else 2):
  - Non-predec: first address = BASE_ADR, then +S per transfer.
  - Predec: first address = BASE_ADR-S, then -S per transfer.
  - Arithmetic is modulo 2^ADR_W; wrap-around is legal and not flagged.
- XFER:
  - BUS_REQ = 1. BUS_ADR, REG_PNTR and BUS_WRn hold stable until BUS_ACK or BUS_ERR.
  - First request is asserted the cycle after START.
- On a BUS_ACK cycle:
  - XFER_CNT increments.
  - REG_WE = MEM2REG in that same cycle, except when POSTINC and REG_PNTR == {1,AN_SEL}: that write is inhibited, but the bus cycle still occurs.
  - If bits remain, the next request is presented the very next cycle with BUS_REQ continuously high. Otherwise go to FIN.
- BUS_ERR while in XFER:
  - Takes precedence over a simultaneous BUS_ACK.
  - Go to FIN with the error flagged. XFER_CNT is not incremented. No AN_UPDATE.
- FIN (one cycle):
  - DONE = 1, ERR = error flag.
  - AN_UPDATE = (PREDEC or POSTINC) and no error.
  - AN_VALUE = BASE_ADR ± N·S, where N = popcount of the latched mask (minus for predec, plus for postinc). An empty mask gives AN_VALUE = BASE_ADR.
  - Then IDLE, with BUSY cleared.
- START while BUSY is ignored. START in the same cycle as a DONE pulse is also ignored.
- BUS_ACK or BUS_ERR while BUS_REQ = 0 is ignored.
- PREDEC and POSTINC both set is illegal. Precedence: PREDEC wins.

Test Plan:
- MASK=16'h8001, POSTINC=1, SIZE_LONG=1, MEM2REG=1, AN_SEL=3, BASE=32'h1000, immediate acks -> requests (D0, 0x1000) then (A7, 0x1004) in consecutive cycles; REG_WE both; DONE with AN_UPDATE, AN_VALUE=0x1008, XFER_CNT=2.
- MASK=16'h0003, PREDEC=1, word, MEM2REG=0, BASE=0x2000 -> (A7, 0x1FFE), (A6, 0x1FFC); REG_WE never; AN_VALUE=0x1FFC.
- MASK=16'h0800 (A3), POSTINC=1, AN_SEL=3, MEM2REG=1, BASE=0x10 -> one bus read at 0x10; REG_WE=0 on the ack; AN_VALUE=0x12 (word).
- MASK=16'h00FF, control mode, BUS_ACK delayed 3 cycles per transfer -> BUS_ADR and REG_PNTR stable during the waits; 8 transfers; DONE with AN_UPDATE=0.
- MASK=16'hFFFF, BUS_ERR together with BUS_ACK on the 3rd transfer -> DONE=1, ERR=1, XFER_CNT=2, AN_UPDATE=0; a START pulsed mid-operation is ignored.
- MASK=0, PREDEC=1, BASE=0x0 -> no BUS_REQ; DONE two cycles after START; AN_VALUE=0. Then long predec with MASK=1 and BASE=0 -> BUS_ADR=0xFFFFFFFC. RESETn pulled low mid-transfer -> all outputs 0 immediately.
